// File: rtl/plic_vector_sequencer_if.sv
// Bundle of the PLIC-core, CPU-vector and status signals around one
// plic_vector_sequencer. The master modport is the sequencer's view; the slave
// modport is the view of the environment (the PLIC core plus the CPU).
interface plic_vector_sequencer_if #(
  parameter int SOURCES_BITS = 7,
  parameter int XLEN         = 32
);
  // PLIC core side
  logic                    enable;
  logic                    ireq;
  logic [SOURCES_BITS-1:0] id;
  logic                    claim;
  logic                    complete;
  logic [SOURCES_BITS-1:0] cur_id;
  // CPU side
  logic                    vec_req;
  logic [XLEN-1:0]         vec_addr;
  logic                    vec_ack;
  logic                    eoi;
  // status
  logic                    busy;
  logic [7:0]              spurious_cnt;
  logic                    timeout_err;

  modport master (
    input  enable, ireq, id, vec_ack, eoi,
    output claim, complete, cur_id, vec_req, vec_addr, busy, spurious_cnt, timeout_err
  );

  modport slave (
    output enable, ireq, id, vec_ack, eoi,
    input  claim, complete, cur_id, vec_req, vec_addr, busy, spurious_cnt, timeout_err
  );
endinterface

// File: rtl/plic_vector_sequencer.sv
// Hardware claim/complete sequencer for one hardware-vectored PLIC target.
// Claims the winning ID, requests the vector fetch from the CPU, waits for
// end-of-interrupt and then issues the matching complete.
//
// Optional build macro: PLIC_VECTOR_TIMEOUT_EN
//   defined   : SERVICE is bounded to TIMEOUT cycles; a forced complete pulses
//               timeout_err together with complete.
//   undefined : SERVICE waits for eoi indefinitely, timeout_err is tied low.
//
// state    | meaning
// ---------+---------------------------------------------------------------
// IDLE     | no interrupt in flight; waits for enable & ireq
// CLAIM    | claim pulse to the PLIC core; id latched into cur_id
// VECTOR   | vector request held to the CPU until vec_ack
// SERVICE  | handler running on the CPU; waits for eoi (or timeout)
// COMPLETE | complete pulse to the PLIC core with cur_id
module plic_vector_sequencer #(
  parameter int              SOURCES      = 64,
  parameter int              SOURCES_BITS = $clog2(SOURCES + 1),
  parameter int              XLEN         = 32,
  parameter logic [XLEN-1:0] VECTOR_BASE  = 'h0000_0100,
  parameter int              VECTOR_SHIFT = 2,
  parameter int              TIMEOUT      = 255
) (
  input  logic                    clk,
  input  logic                    rst,
  plic_vector_sequencer_if.master bus
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_CLAIM    = 3'd1,
    S_VECTOR   = 3'd2,
    S_SERVICE  = 3'd3,
    S_COMPLETE = 3'd4
  } state_t;

  state_t                  state_q, state_d;
  logic [SOURCES_BITS-1:0] cur_id_q, cur_id_d;
  logic [XLEN-1:0]         vec_addr_q, vec_addr_d;
  logic [7:0]              spur_cnt_q, spur_cnt_d;
  logic                    tmo_hit;

`ifdef PLIC_VECTOR_TIMEOUT_EN
  localparam int              TMO_W    = $clog2(TIMEOUT + 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);

  logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;
  logic             tmo_err_q, tmo_err_d;

  // Count SERVICE cycles; the counter is parked at zero while the vector is
  // outstanding so it always starts clean on SERVICE entry.
  always_comb begin
    tmo_cnt_d = tmo_cnt_q;
    if (state_q == S_VECTOR) begin
      tmo_cnt_d = '0;
    end else if (state_q == S_SERVICE) begin
      tmo_cnt_d = tmo_cnt_q + 1'b1;
    end
  end

  // eoi on the terminal cycle wins, so a hit needs eoi low.
  assign tmo_hit   = (state_q == S_SERVICE) && !bus.eoi && (tmo_cnt_q == TMO_LAST);
  assign tmo_err_d = tmo_hit;

  // Timeout counter and error flag registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tmo_cnt_q <= '0;
      tmo_err_q <= 1'b0;
    end else begin
      tmo_cnt_q <= tmo_cnt_d;
      tmo_err_q <= tmo_err_d;
    end
  end

  assign bus.timeout_err = tmo_err_q;
`else
  assign tmo_hit         = 1'b0;
  assign bus.timeout_err = 1'b0;
`endif

  // Next-state and datapath update for the claim/vector/complete sequence.
  always_comb begin
    state_d    = state_q;
    cur_id_d   = cur_id_q;
    vec_addr_d = vec_addr_q;
    spur_cnt_d = spur_cnt_q;

    unique case (state_q)
      S_IDLE: begin
        if (bus.enable && bus.ireq) begin
          state_d = S_CLAIM;
        end
      end

      S_CLAIM: begin
        // The vector address is computed here from the raw id so it is a
        // registered value by the first VECTOR cycle.
        cur_id_d   = bus.id;
        vec_addr_d = VECTOR_BASE + (XLEN'(bus.id) << VECTOR_SHIFT);
        if (bus.id == '0) begin
          if (spur_cnt_q != 8'hFF) begin
            spur_cnt_d = spur_cnt_q + 8'd1;
          end
          state_d = S_IDLE;
        end else begin
          state_d = S_VECTOR;
        end
      end

      S_VECTOR: begin
        if (bus.vec_ack) begin
          state_d = S_SERVICE;
        end
      end

      S_SERVICE: begin
        if (bus.eoi || tmo_hit) begin
          state_d = S_COMPLETE;
        end
      end

      S_COMPLETE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers; reset drops any claimed ID without a complete.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      cur_id_q   <= '0;
      vec_addr_q <= '0;
      spur_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      cur_id_q   <= cur_id_d;
      vec_addr_q <= vec_addr_d;
      spur_cnt_q <= spur_cnt_d;
    end
  end

  // All outputs come straight from registered state or registered data.
  assign bus.claim        = (state_q == S_CLAIM);
  assign bus.complete     = (state_q == S_COMPLETE);
  assign bus.vec_req      = (state_q == S_VECTOR);
  assign bus.busy         = (state_q != S_IDLE);
  assign bus.cur_id       = cur_id_q;
  assign bus.vec_addr     = vec_addr_q;
  assign bus.spurious_cnt = spur_cnt_q;

endmodule

// File: tb/tb_plic_vector_sequencer.sv
// Self-checking bench for plic_vector_sequencer: directed table of sequences,
// spurious-claim saturation, enable gating, reset in SERVICE and a randomized
// phase checked against a transaction-level model of the claim/complete flow.
module tb_plic_vector_sequencer;
  localparam int          SB    = 7;
  localparam int          XL    = 32;
  localparam int          SHIFT = 2;
  localparam int          TMO   = 8;
  localparam logic [31:0] VBASE = 32'h0000_0100;
`ifdef PLIC_VECTOR_TIMEOUT_EN
  localparam bit TMO_EN = 1'b1;
`else
  localparam bit TMO_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  plic_vector_sequencer_if #(.SOURCES_BITS(SB), .XLEN(XL)) bus ();

  plic_vector_sequencer #(
    .SOURCES(64), .XLEN(XL), .VECTOR_BASE(VBASE),
    .VECTOR_SHIFT(SHIFT), .TIMEOUT(TMO)
  ) u_dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  typedef struct {
    int          id;
    int          ack_dly;
    int          eoi_dly;
    bit          stray;
    bit          drop_en;
    logic [31:0] exp_addr;
  } vec_t;

  int n_run  = 0;
  int n_fail = 0;
  int model_spur = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] model_addr(input int id);
    longint a;
    a = longint'(VBASE) + (longint'(id) * (longint'(1) << SHIFT));
    return a[31:0];
  endfunction

  // One full transaction starting from IDLE. eoi_dly = SERVICE cycles without
  // eoi before the eoi cycle.
  task automatic do_seq(input int id, input int ack_dly, input int eoi_dly,
                        input bit stray, input bit drop_en, input logic [31:0] exp_addr);
    bit tmo_exp;
    int svc_len;
    bus.enable = 1'b1;
    bus.ireq   = 1'b1;
    bus.id     = SB'(id);
    tick();
    chk("claim_pulse", 64'(bus.claim), 64'(1));
    chk("claim_no_vreq", 64'(bus.vec_req), 64'(0));
    chk("claim_no_cmp", 64'(bus.complete), 64'(0));
    bus.ireq = 1'($urandom_range(0, 1));
    tick();
    if (id == 0) begin
      model_spur = (model_spur < 255) ? model_spur + 1 : 255;
      chk("spur_idle", 64'(bus.busy), 64'(0));
      chk("spur_no_vreq", 64'(bus.vec_req), 64'(0));
      chk("spur_cnt", 64'(bus.spurious_cnt), 64'(model_spur));
      bus.ireq = 1'b0;
      return;
    end
    for (int k = 0; k <= ack_dly; k++) begin
      chk("vec_req", 64'(bus.vec_req), 64'(1));
      chk("vec_addr", 64'(bus.vec_addr), 64'(exp_addr));
      chk("vec_cur_id", 64'(bus.cur_id), 64'(id));
      chk("vec_no_claim", 64'(bus.claim), 64'(0));
      bus.vec_ack = (k == ack_dly);
      bus.eoi     = stray && 1'($urandom_range(0, 1));
      tick();
    end
    bus.vec_ack = 1'b0;
    bus.eoi     = 1'b0;
    if (drop_en) bus.enable = 1'b0;
    tmo_exp = TMO_EN && (eoi_dly >= TMO);
    svc_len = tmo_exp ? TMO : eoi_dly + 1;
    for (int k = 1; k <= svc_len; k++) begin
      chk("svc_no_vreq", 64'(bus.vec_req), 64'(0));
      chk("svc_no_cmp", 64'(bus.complete), 64'(0));
      chk("svc_busy", 64'(bus.busy), 64'(1));
      bus.vec_ack = 1'($urandom_range(0, 1));
      bus.eoi     = (k == eoi_dly + 1);
      tick();
    end
    bus.eoi     = 1'b0;
    bus.vec_ack = 1'b0;
    bus.ireq    = 1'b0;
    chk("cmp_pulse", 64'(bus.complete), 64'(1));
    chk("cmp_cur_id", 64'(bus.cur_id), 64'(id));
    chk("cmp_no_claim", 64'(bus.claim), 64'(0));
    chk("cmp_timeout_err", 64'(bus.timeout_err), 64'(tmo_exp));
    tick();
    chk("post_idle", 64'(bus.busy), 64'(0));
    chk("post_no_cmp", 64'(bus.complete), 64'(0));
    chk("post_no_terr", 64'(bus.timeout_err), 64'(0));
    chk("post_cur_id_hold", 64'(bus.cur_id), 64'(id));
    bus.enable = 1'b1;
  endtask

  initial begin
    repeat (50000) @(posedge clk);
    $display("FAIL watchdog: simulation exceeded cycle budget");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl[6];
    tbl[0] = '{id: 5,   ack_dly: 0,  eoi_dly: 10, stray: 0, drop_en: 0, exp_addr: 32'h0000_0114};
    tbl[1] = '{id: 1,   ack_dly: 3,  eoi_dly: 0,  stray: 0, drop_en: 0, exp_addr: 32'h0000_0104};
    tbl[2] = '{id: 63,  ack_dly: 1,  eoi_dly: 7,  stray: 0, drop_en: 1, exp_addr: 32'h0000_01FC};
    tbl[3] = '{id: 64,  ack_dly: 20, eoi_dly: 3,  stray: 1, drop_en: 0, exp_addr: 32'h0000_0200};
    tbl[4] = '{id: 127, ack_dly: 0,  eoi_dly: 8,  stray: 1, drop_en: 1, exp_addr: 32'h0000_02FC};
    tbl[5] = '{id: 2,   ack_dly: 0,  eoi_dly: 0,  stray: 0, drop_en: 0, exp_addr: 32'h0000_0108};

    rst = 1'b1;
    bus.enable  = 1'b0;
    bus.ireq    = 1'b0;
    bus.id      = '0;
    bus.vec_ack = 1'b0;
    bus.eoi     = 1'b0;
    tick();
    tick();
    chk("rst_claim", 64'(bus.claim), 64'(0));
    chk("rst_complete", 64'(bus.complete), 64'(0));
    chk("rst_vec_req", 64'(bus.vec_req), 64'(0));
    chk("rst_busy", 64'(bus.busy), 64'(0));
    chk("rst_timeout_err", 64'(bus.timeout_err), 64'(0));
    chk("rst_cur_id", 64'(bus.cur_id), 64'(0));
    chk("rst_vec_addr", 64'(bus.vec_addr), 64'(0));
    chk("rst_spur", 64'(bus.spurious_cnt), 64'(0));
    rst = 1'b0;
    tick();

    // enable low blocks new claims
    bus.enable = 1'b0;
    bus.ireq   = 1'b1;
    bus.id     = SB'(3);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("dis_no_claim", 64'(bus.claim), 64'(0));
      chk("dis_idle", 64'(bus.busy), 64'(0));
    end
    bus.ireq = 1'b0;

    // directed table, applied back-to-back
    for (int i = 0; i < 6; i++) begin
      do_seq(tbl[i].id, tbl[i].ack_dly, tbl[i].eoi_dly, tbl[i].stray, tbl[i].drop_en, tbl[i].exp_addr);
    end

    // spurious claims saturate the counter
    for (int i = 0; i < 300; i++) begin
      do_seq(0, 0, 0, 1'b0, 1'b0, 32'h0);
    end
    chk("spur_saturated", 64'(bus.spurious_cnt), 64'(255));

    // reset during SERVICE with cur_id 9
    bus.enable = 1'b1;
    bus.ireq   = 1'b1;
    bus.id     = SB'(9);
    tick();
    bus.ireq = 1'b0;
    tick();
    bus.vec_ack = 1'b1;
    tick();
    bus.vec_ack = 1'b0;
    tick();
    chk("svc9_cur_id", 64'(bus.cur_id), 64'(9));
    chk("svc9_busy", 64'(bus.busy), 64'(1));
    rst = 1'b1;
    model_spur = 0;
    #1;
    chk("midrst_busy", 64'(bus.busy), 64'(0));
    chk("midrst_complete", 64'(bus.complete), 64'(0));
    chk("midrst_cur_id", 64'(bus.cur_id), 64'(0));
    chk("midrst_vec_addr", 64'(bus.vec_addr), 64'(0));
    chk("midrst_spur", 64'(bus.spurious_cnt), 64'(0));
    tick();
    rst = 1'b0;
    bus.eoi = 1'b1;
    tick();
    bus.eoi = 1'b0;
    chk("postrst_no_cmp", 64'(bus.complete), 64'(0));
    chk("postrst_idle", 64'(bus.busy), 64'(0));
    tick();
    chk("postrst_no_cmp2", 64'(bus.complete), 64'(0));

    // randomized transactions against the model
    for (int i = 0; i < 40; i++) begin
      int id;
      int gap;
      gap = int'($urandom_range(0, 3));
      for (int g = 0; g < gap; g++) begin
        bus.enable = 1'b0;
        bus.ireq   = 1'($urandom_range(0, 1));
        tick();
        chk("rnd_gap_no_claim", 64'(bus.claim), 64'(0));
        chk("rnd_gap_idle", 64'(bus.busy), 64'(0));
      end
      id = int'($urandom_range(0, 70));
      if ($urandom_range(0, 4) == 0) id = 0;
      do_seq(id, int'($urandom_range(0, 4)), int'($urandom_range(0, 11)),
             1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), model_addr(id));
    end
    chk("rnd_spur_final", 64'(bus.spurious_cnt), 64'(model_spur));

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
